// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN          : datapath width
//   NOP_INST_C    : canonical NOP (addi x0, x0, 0) shown when no instruction is live
//   fetch_state_e : fetch FSM encoding
//   if_payload_t  : {pc, inst} pair carried by the hold buffer
//   pc_incr()     : sequential PC step, wraps modulo 2^XLEN
//   word_align()  : forces bits [1:0] of an address to zero
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST_C = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_payload_t;

  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// -----------------------------------------------------------------------------
// if_hold_buf
// One-entry skid register that parks a fetched {pc, inst} while the output
// slot is blocked by a downstream stall.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset (entry empty)
//   load     : capture pc_in/inst_in, mark full
//   unload   : mark empty (data has been moved out)
//   clear    : discard the entry (redirect flush); wins over load/unload
//   pc_in    : pc to capture
//   inst_in  : instruction to capture
//   pc_out   : parked pc
//   inst_out : parked instruction
//   full     : entry holds a live instruction
// -----------------------------------------------------------------------------
module if_hold_buf
  import riscv_pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] inst_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] inst_out,
  output logic            full
);

  if_payload_t entry_q;
  logic        full_q;

  // Entry storage and occupancy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else if (clear) begin
      entry_q <= entry_q;
      full_q  <= 1'b0;
    end else if (load) begin
      entry_q <= '{pc: pc_in, inst: inst_in};
      full_q  <= 1'b1;
    end else if (unload) begin
      entry_q <= entry_q;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_q;
      full_q  <= full_q;
    end
  end

  assign pc_out   = entry_q.pc;
  assign inst_out = entry_q.inst;
  assign full     = full_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, issues one
// outstanding request at a time, absorbs stalls with a one-entry hold buffer
// and restarts fetch on branch/jump redirects.
// Parameters:
//   RESET_PC : first fetch address after reset
//   NOP_INST : value on inst_o while no valid instruction is held
// Ports:
//   clk_i, reset_i        : clock (rising edge), asynchronous active-high reset
//   imem_req_o/addr_o     : fetch request and word-aligned address (= pc)
//   imem_ready_i          : request accepted when req & ready
//   imem_rvalid_i/rdata_i : response strobe and instruction word
//   stall_i               : downstream hazard, presented instruction is held
//   redirect_i/pc_i       : flush and restart at redirect_pc_i (bits [1:0] ignored)
//   valid_o, pc_o, inst_o, pcplus4_o : registered IF/ID payload
// Optional build macro IF_FETCH_PERF_CNT_EN adds saturating counters:
//   perf_fetched_o : instructions loaded into the outputs
//   perf_stall_o   : cycles with valid_o & stall_i
// -----------------------------------------------------------------------------
module if_fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] pcplus4_o
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_REQ   = REQ;
  localparam logic [2:0] ST_WAIT  = WAIT;
  localparam logic [2:0] ST_HOLD  = HOLD;
  localparam logic [2:0] ST_DRAIN = DRAIN;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        slot_free;
  logic        flush;
  logic        load_out;
  logic [31:0] load_pc;
  logic [31:0] load_inst;

  logic        hold_load, hold_unload, hold_clear;
  logic [31:0] hold_pc, hold_inst;
  logic        hold_full;

  assign slot_free   = !valid_o || !stall_i;
  assign imem_req_o  = (state_q == ST_REQ);
  assign imem_addr_o = pc_q;

  if_hold_buf u_hold_buf (
    .clk      (clk_i),
    .rst      (reset_i),
    .load     (hold_load),
    .unload   (hold_unload),
    .clear    (hold_clear),
    .pc_in    (pc_q),
    .inst_in  (imem_rdata_i),
    .pc_out   (hold_pc),
    .inst_out (hold_inst),
    .full     (hold_full)
  );

  // Next-state, next-PC and output-load decisions; redirect overrides all.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush       = 1'b0;
    load_out    = 1'b0;
    load_pc     = pc_q;
    load_inst   = imem_rdata_i;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    hold_clear  = 1'b0;

    if (redirect_i) begin
      flush      = 1'b1;
      hold_clear = 1'b1;
      pc_d       = word_align(redirect_pc_i);
      // A request already accepted leaves a stale response in flight: drain it.
      case (state_q)
        ST_REQ:   state_d = imem_ready_i  ? ST_DRAIN : ST_REQ;
        ST_WAIT:  state_d = imem_rvalid_i ? ST_REQ   : ST_DRAIN;
        ST_DRAIN: state_d = imem_rvalid_i ? ST_REQ   : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (imem_ready_i) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid_i) begin
            pc_d = pc_incr(pc_q);
            if (slot_free) begin
              load_out = 1'b1;
              state_d  = ST_REQ;
            end else begin
              hold_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall_i && hold_full) begin
            load_out    = 1'b1;
            load_pc     = hold_pc;
            load_inst   = hold_inst;
            hold_unload = 1'b1;
            state_d     = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state and program counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // IF/ID payload: flush, load, retire (consumed with nothing new), or hold.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o   <= 1'b0;
      pc_o      <= 32'h0000_0000;
      inst_o    <= NOP_INST;
      pcplus4_o <= 32'h0000_0000;
    end else if (flush) begin
      valid_o   <= 1'b0;
      inst_o    <= NOP_INST;
    end else if (load_out) begin
      valid_o   <= 1'b1;
      pc_o      <= load_pc;
      inst_o    <= load_inst;
      pcplus4_o <= pc_incr(load_pc);
    end else if (valid_o && !stall_i) begin
      valid_o   <= 1'b0;
      inst_o    <= NOP_INST;
    end else begin
      valid_o   <= valid_o;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_fetched_o <= 32'h0000_0000;
      perf_stall_o   <= 32'h0000_0000;
    end else begin
      if (load_out && (perf_fetched_o != 32'hFFFF_FFFF)) begin
        perf_fetched_o <= perf_fetched_o + 32'd1;
      end else begin
        perf_fetched_o <= perf_fetched_o;
      end
      if (valid_o && stall_i && (perf_stall_o != 32'hFFFF_FFFF)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end else begin
        perf_stall_o <= perf_stall_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit. A second instance with RESET_PC at the top
// of the address space shares all inputs and covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        req_a, valid_a;
  logic [31:0] addr_a, pc_a, inst_a, pc4_a;
  logic        req_b, valid_b;
  logic [31:0] addr_b, pc_b, inst_b, pc4_b;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .reset_i(reset),
    .imem_req_o(req_a), .imem_addr_o(addr_a),
    .imem_ready_i(imem_ready), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .valid_o(valid_a), .pc_o(pc_a), .inst_o(inst_a), .pcplus4_o(pc4_a)
`ifdef IF_FETCH_PERF_CNT_EN
    , .perf_fetched_o(pf_a), .perf_stall_o(ps_a)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .reset_i(reset),
    .imem_req_o(req_b), .imem_addr_o(addr_b),
    .imem_ready_i(imem_ready), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .valid_o(valid_b), .pc_o(pc_b), .inst_o(inst_b), .pcplus4_o(pc4_b)
`ifdef IF_FETCH_PERF_CNT_EN
    , .perf_fetched_o(pf_b), .perf_stall_o(ps_b)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the DUT in REQ at pc; accept next edge, respond the edge after.
  task automatic fetch_one(input logic [31:0] pc);
    imem_rvalid = 1'b0;
    check1("req_issued", req_a, 1'b1);
    check32("req_addr", addr_a, pc);
    step();
    check1("req_low_in_wait", req_a, 1'b0);
    check1("valid_retired", valid_a, 1'b0);
    check32("inst_nop_idle", inst_a, NOP);
    imem_rvalid = 1'b1;
    imem_rdata  = pc ^ K;
    step();
    check1("valid_load", valid_a, 1'b1);
    check32("pc_o", pc_a, pc);
    check32("inst_o", inst_a, pc ^ K);
    check32("pcplus4_o", pc4_a, pc + 32'd4);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
  endtask

  initial begin
    reset       = 1'b1;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_valid", valid_a, 1'b0);
    check32("rst_pc", pc_a, 32'h0000_0000);
    check32("rst_inst", inst_a, NOP);
    check32("rst_pc4", pc4_a, 32'h0000_0000);
    check1("rst_req", req_a, 1'b0);
    check32("rst_addr", addr_a, 32'h0000_0000);
    check32("rst_addr_wrap", addr_b, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Streaming with zero-wait memory
    step();
    check32("wrap_first_addr", addr_b, 32'hFFFF_FFFC);
    fetch_one(32'h0000_0000);
    check32("wrap_pc_o", pc_b, 32'hFFFF_FFFC);
    check32("wrap_pcplus4", pc4_b, 32'h0000_0000);
    check32("wrap_second_addr", addr_b, 32'h0000_0000);
    check1("wrap_req", req_b, 1'b1);
    fetch_one(32'h0000_0004);
    fetch_one(32'h0000_0008);
    check32("addr_after_8", addr_a, 32'h0000_000C);

    // Stall held 5 cycles while response for pc 12 arrives
    stall = 1'b1;
    step();
    check1("stall_valid_held", valid_a, 1'b1);
    check32("stall_pc_held", pc_a, 32'h0000_0008);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_000C ^ K;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    check1("hold_no_req", req_a, 1'b0);
    check32("hold_pc_unchanged", pc_a, 32'h0000_0008);
    check32("hold_inst_unchanged", inst_a, 32'h0000_0008 ^ K);
    for (int i = 0; i < 3; i++) begin
      step();
      check1("hold_no_req_loop", req_a, 1'b0);
      check1("hold_valid_loop", valid_a, 1'b1);
      check32("hold_pc_loop", pc_a, 32'h0000_0008);
    end
    stall = 1'b0;
    step();
    check1("unhold_valid", valid_a, 1'b1);
    check32("unhold_pc", pc_a, 32'h0000_000C);
    check32("unhold_inst", inst_a, 32'h0000_000C ^ K);
    check32("unhold_pc4", pc4_a, 32'h0000_0010);
    fetch_one(32'h0000_0010);

    // Redirect while waiting; stale response 3 cycles later
    step();
    check1("pre_redirect_wait", req_a, 1'b0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check1("redir_valid", valid_a, 1'b0);
    check32("redir_inst", inst_a, NOP);
    check1("drain_no_req", req_a, 1'b0);
    check32("drain_addr", addr_a, 32'h0000_0100);
    step();
    check1("drain_valid_1", valid_a, 1'b0);
    step();
    check1("drain_valid_2", valid_a, 1'b0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check1("drain_done_valid", valid_a, 1'b0);
    check32("drain_done_inst", inst_a, NOP);
    fetch_one(32'h0000_0100);

    // Redirect in the same cycle as rvalid
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0104 ^ K;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    check1("redir_rv_valid", valid_a, 1'b0);
    check32("redir_rv_inst", inst_a, NOP);
    check32("redir_rv_addr", addr_a, 32'h0000_0200);
    fetch_one(32'h0000_0200);

    // Redirect together with stall (request accepted the same cycle)
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0302;
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    check1("redir_stall_valid", valid_a, 1'b0);
    check32("redir_stall_inst", inst_a, NOP);
    check1("redir_stall_drain_req", req_a, 1'b0);
    check32("redir_stall_addr", addr_a, 32'h0000_0300);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    check1("post_drain_req", req_a, 1'b1);
    check1("post_drain_valid", valid_a, 1'b0);
`ifdef IF_FETCH_PERF_CNT_EN
    check32("perf_fetched", pf_a, 32'd7);
    check32("perf_stall", ps_a, 32'd6);
`endif

    // Asynchronous reset mid-WAIT
    step();
    check1("pre_reset_wait", req_a, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check1("async_rst_valid", valid_a, 1'b0);
    check32("async_rst_pc", pc_a, 32'h0000_0000);
    check32("async_rst_inst", inst_a, NOP);
    check32("async_rst_pc4", pc4_a, 32'h0000_0000);
    check1("async_rst_req", req_a, 1'b0);
    check32("async_rst_addr", addr_a, 32'h0000_0000);
    check32("async_rst_addr_wrap", addr_b, 32'hFFFF_FFFC);
`ifdef IF_FETCH_PERF_CNT_EN
    check32("rst_perf_fetched", pf_a, 32'd0);
    check32("rst_perf_stall", ps_a, 32'd0);
`endif
    step();
    reset       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0300 ^ K;
    step();
    check1("late_rv_idle_valid", valid_a, 1'b0);
    check1("post_rst_req", req_a, 1'b1);
    check32("post_rst_addr", addr_a, 32'h0000_0000);
    step();
    check1("late_rv_req_valid", valid_a, 1'b0);
    check32("late_rv_req_inst", inst_a, NOP);
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    fetch_one(32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one-outstanding-request fetches to instruction memory.
- Absorbs memory latency and downstream stalls through a one-entry hold buffer.
- Drives pc/inst/pcplus4 plus a valid qualifier into IF/ID; honours branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, value driven on inst_o while no valid instruction is held.

Ports:
- clk_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address, word aligned.
- imem_ready_i  in  1  memory accepts the request when imem_req_o & imem_ready_i.
- imem_rvalid_i  in  1  read data valid, at least 1 cycle after accept.
- imem_rdata_i  in  32  fetched instruction.
- stall_i  in  1  downstream hazard; hold outputs.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (treated as 0).
- valid_o  out  1  pc_o/inst_o/pcplus4_o hold a live instruction.
- pc_o  out  32  PC of presented instruction.
- inst_o  out  32  presented instruction.
- pcplus4_o  out  32  pc_o + 4, modulo 2^32.

Behaviour:
- Reset (async assert) forces the following; deassertion is synchronised by the first clock edge:
  - pc_q = RESET_PC, state = IDLE.
  - valid_o = 0, pc_o = 0, inst_o = NOP_INST, pcplus4_o = 0.
  - imem_req_o = 0, imem_addr_o = RESET_PC, hold buffer empty.
- imem_addr_o = pc_q at all times; imem_req_o = 1 only in REQ.
- Output slot is free when !valid_o | !stall_i.
- When valid_o & !stall_i and nothing new is loaded that cycle, valid_o <= 0 and inst_o <= NOP_INST.
- FSM states and transitions:
  - IDLE: one cycle after reset release -> REQ. First imem_req_o appears 1 cycle after reset release.
  - REQ: on accept -> WAIT.
  - WAIT, on rvalid:
    - If slot free: load outputs (pc_o = pc_q, inst_o = rdata, pcplus4_o = pc_q + 4, valid_o = 1), pc_q += 4, -> REQ.
    - Else: capture {pc_q, rdata} in hold buffer, pc_q += 4, -> HOLD.
  - HOLD: when !stall_i, move buffer to outputs with valid_o = 1, -> REQ.
  - DRAIN: wait for rvalid, discard data, -> REQ.
- Throughput: with zero-wait memory (ready = 1, rvalid one cycle after accept), one instruction every 2 cycles.
- Redirect has priority over everything except reset. On redirect_i in any state:
  - pc_q <= {redirect_pc_i[31:2], 2'b00}, valid_o <= 0, inst_o <= NOP_INST, hold buffer cleared. This happens even when stall_i = 1.
  - From IDLE/HOLD, or REQ without accept -> REQ.
  - From REQ with accept the same cycle, or WAIT without rvalid -> DRAIN (stale response outstanding).
  - From WAIT with rvalid the same cycle: data dropped -> REQ.
  - From DRAIN with rvalid the same cycle -> REQ; without rvalid -> stay in DRAIN with the new pc_q.
- PC arithmetic: 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.
- A stray rvalid in IDLE/REQ/HOLD is ignored.
- Reset mid-transaction: all state is discarded; a response arriving after reset release in IDLE/REQ is ignored.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched_o[31:0] and perf_stall_o[31:0], both reset to 0.
  - perf_fetched_o increments on each instruction loaded into the outputs.
  - perf_stall_o increments each cycle with valid_o & stall_i.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (riscv_pipe_pkg):
  - fetch_state_e enum {IDLE, REQ, WAIT, HOLD, DRAIN}.
  - NOP_INST_C = 32'h0000_0013.
  - XLEN = 32.
  - if_payload_t struct {pc, inst}.
- One natural sub-module: if_hold_buf, a one-entry skid register with load/unload/clear.

Test Plan:
- Reset release, ready = 1, rvalid one cycle after each accept, rdata = addr ^ 32'hA5A5_0000 -> first req 1 cycle after release at addr 0; valid_o pulses with pc_o = 0, 4, 8; pcplus4_o = 4, 8, 12.
- stall_i held 5 cycles while a response arrives -> captured in hold buffer; outputs unchanged; no new req during HOLD; after release, pc_o advances by exactly 4 with nothing lost or duplicated.
- redirect_i with redirect_pc_i = 32'h0000_0103 while in WAIT, rvalid 3 cycles later -> state DRAIN; stale data never reaches outputs; next req at 32'h0000_0100; valid_o = 0 in the cycle after redirect.
- redirect_i in the same cycle as rvalid, and separately in the same cycle as stall_i = 1 -> data dropped; valid_o = 0 and inst_o = 32'h0000_0013 next cycle.
- RESET_PC = 32'hFFFF_FFFC -> second fetch address wraps to 32'h0000_0000; pcplus4_o = 0 for the first instruction.
- reset_i asserted asynchronously mid-WAIT -> outputs immediately at reset values; late rvalid after release ignored; first req at RESET_PC; with IF_FETCH_PERF_CNT_EN, both counters read 0.
